alu_iter: RTL

Parametrised, multi-cycle successor to the core's combinational ALU. It accepts one operation per valid/ready handshake and operates on byte or word operands. It produces 8086/V30-style status flags. Multi-bit shifts and rotates are iterated one bit per cycle, and completion is signalled with a one-cycle result strobe. The block sits between the execute-stage sequencer and the register file / PSW.

---
 rtl/alu_iter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with 8086-style flags. Logic and arithmetic ops
// complete in one cycle; shifts and rotates iterate one bit per cycle.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | iterating a shift/rotate, one bit per cycle
// DONE  | result and flags valid, out_valid high for this cycle
module alu_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             word,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       count,
  input  logic [5:0]       flags_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [5:0]       flags_out
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] MASK_B = {{(WIDTH-H){1'b0}}, {H{1'b1}}};
  localparam logic [WIDTH-1:0] TOP_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] TOP_B  = {{(WIDTH-H){1'b0}}, 1'b1, {(H-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [4:0] OP_AND = 5'd0;
  localparam logic [4:0] OP_OR  = 5'd1;
  localparam logic [4:0] OP_XOR = 5'd2;
  localparam logic [4:0] OP_ADD = 5'd3;
  localparam logic [4:0] OP_ADC = 5'd4;
  localparam logic [4:0] OP_SUB = 5'd5;
  localparam logic [4:0] OP_SBB = 5'd6;
  localparam logic [4:0] OP_INC = 5'd7;
  localparam logic [4:0] OP_DEC = 5'd8;
  localparam logic [4:0] OP_NEG = 5'd9;
  localparam logic [4:0] OP_ROL = 5'd10;
  localparam logic [4:0] OP_ROR = 5'd11;
  localparam logic [4:0] OP_RCL = 5'd12;
  localparam logic [4:0] OP_RCR = 5'd13;
  localparam logic [4:0] OP_SHL = 5'd14;
  localparam logic [4:0] OP_SHR = 5'd15;
  localparam logic [4:0] OP_SAR = 5'd16;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  // Iteration registers, loaded at acceptance of a shift/rotate
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [4:0]       cnt;
  logic [4:0]       op_q;
  logic             word_q;
  logic [3:0]       pass_q;   // captured {SF,ZF,AF,PF}, passed through by rotates
  logic             a_msb_q;  // original sign bit, needed for SHR overflow

  logic             accept;
  logic             is_shift;

  logic [WIDTH-1:0] mask_in, a_m, b_m, x, y;
  logic             cy;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sum_res, diff_res, alu_res;
  logic [5:0]       alu_flags;
  logic             cf, of, af, upd;

  logic [WIDTH-1:0] mask_q, top_q, shl, shr, step_w;
  logic             msb_q, step_c, fin_msb, fin_msb2, fin_of;
  logic [5:0]       fin_flags;

  function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic w);
    msb_of = w ? v[WIDTH-1] : v[H-1];
  endfunction

  assign accept   = in_valid && in_ready;
  assign is_shift = (op >= OP_ROL) && (op <= OP_SAR);

  // Single-cycle logic/arithmetic result and flags from the live inputs
  always_comb begin
    mask_in = word ? {WIDTH{1'b1}} : MASK_B;
    a_m     = a & mask_in;
    b_m     = b & mask_in;
    x       = a_m;
    y       = b_m;
    cy      = 1'b0;
    case (op)
      OP_ADC, OP_SBB: cy = flags_in[0];
      OP_INC, OP_DEC: y = ONE;
      OP_NEG: begin
        x = '0;
        y = a_m;
      end
      default: ;
    endcase
    sum      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cy};
    diff     = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cy};
    sum_res  = sum[WIDTH-1:0] & mask_in;
    diff_res = diff[WIDTH-1:0] & mask_in;

    alu_res   = '0;
    alu_flags = flags_in;
    cf        = 1'b0;
    of        = 1'b0;
    af        = 1'b0;
    upd       = 1'b1;
    case (op)
      OP_AND: alu_res = a_m & b_m;
      OP_OR:  alu_res = a_m | b_m;
      OP_XOR: alu_res = a_m ^ b_m;
      OP_ADD, OP_ADC, OP_INC: begin
        alu_res = sum_res;
        cf = (op == OP_INC) ? flags_in[0] : (word ? sum[WIDTH] : sum[H]);
        af = x[4] ^ y[4] ^ sum_res[4];
        of = (msb_of(x, word) == msb_of(y, word)) &&
             (msb_of(sum_res, word) != msb_of(x, word));
      end
      OP_SUB, OP_SBB, OP_DEC, OP_NEG: begin
        alu_res = diff_res;
        cf = (op == OP_DEC) ? flags_in[0] : (word ? diff[WIDTH] : diff[H]);
        af = x[4] ^ y[4] ^ diff_res[4];
        of = (msb_of(x, word) != msb_of(y, word)) &&
             (msb_of(diff_res, word) != msb_of(x, word));
      end
      default: upd = 1'b0;
    endcase
    if (upd) begin
      alu_flags = {of, msb_of(alu_res, word), (alu_res == '0), af,
                   ~^alu_res[7:0], cf};
    end
  end

  // One-bit shift/rotate step and the flags of the state after that step
  always_comb begin
    mask_q = word_q ? {WIDTH{1'b1}} : MASK_B;
    top_q  = word_q ? TOP_W : TOP_B;
    msb_q  = msb_of(work, word_q);
    shl    = (work << 1) & mask_q;
    shr    = work >> 1;
    step_w = work;
    step_c = carry;
    case (op_q)
      OP_ROL: begin
        step_w = shl | {{(WIDTH-1){1'b0}}, msb_q};
        step_c = msb_q;
      end
      OP_ROR: begin
        step_w = shr | (work[0] ? top_q : '0);
        step_c = work[0];
      end
      OP_RCL: begin
        step_w = shl | {{(WIDTH-1){1'b0}}, carry};
        step_c = msb_q;
      end
      OP_RCR: begin
        step_w = shr | (carry ? top_q : '0);
        step_c = work[0];
      end
      OP_SHL: begin
        step_w = shl;
        step_c = msb_q;
      end
      OP_SHR: begin
        step_w = shr;
        step_c = work[0];
      end
      OP_SAR: begin
        step_w = shr | (msb_q ? top_q : '0);
        step_c = work[0];
      end
      default: ;
    endcase

    fin_msb  = msb_of(step_w, word_q);
    fin_msb2 = word_q ? step_w[WIDTH-2] : step_w[H-2];
    case (op_q)
      OP_ROL, OP_RCL, OP_SHL: fin_of = fin_msb ^ step_c;
      OP_ROR, OP_RCR:         fin_of = fin_msb ^ fin_msb2;
      OP_SHR:                 fin_of = a_msb_q;
      default:                fin_of = 1'b0;
    endcase
    if (op_q <= OP_RCR) begin
      fin_flags = {fin_of, pass_q, step_c};
    end else begin
      fin_flags = {fin_of, fin_msb, (step_w == '0), 1'b0, ~^step_w[7:0], step_c};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (is_shift && (count != 5'd0)) ? SHIFT : DONE;
        end
      end
      SHIFT: if (cnt == 5'd1) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      pass_q    <= '0;
      a_msb_q   <= 1'b0;
      result    <= '0;
      flags_out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q    <= op;
          word_q  <= word;
          pass_q  <= flags_in[4:1];
          work    <= a_m;
          carry   <= flags_in[0];
          cnt     <= count;
          a_msb_q <= msb_of(a_m, word);
          if (!is_shift) begin
            result    <= alu_res;
            flags_out <= alu_flags;
          end else if (count == 5'd0) begin
            result    <= a_m;
            flags_out <= flags_in;
          end
        end
        SHIFT: begin
          work  <= step_w;
          carry <= step_c;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result    <= step_w;
            flags_out <= fin_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
